// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: load size encodings, FSM states, datapath widths.
package writeback_stage_pkg;

  localparam int WORD_W   = 32;
  localparam int DOUBLE_W = 64;

  localparam logic [1:0] DSZ_BYTE = 2'b00;
  localparam logic [1:0] DSZ_HALF = 2'b01;
  localparam logic [1:0] DSZ_WORD = 2'b10;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WR_LO = 1'b1
  } wbState_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Extracts a byte/halfword/word from a big-endian memory word and sign- or zero-extends it.
module load_extend
  import writeback_stage_pkg::*;
(
  input  logic [0:31] dataOut,
  input  logic [0:1]  offset,
  input  logic [0:1]  dSize,
  input  logic        loadSign,
  output logic [0:31] word
);

  function automatic logic [31:0] extendByte(input logic [7:0] f, input logic s);
    return {{24{s & f[7]}}, f};
  endfunction

  function automatic logic [31:0] extendHalf(input logic [15:0] f, input logic s);
    return {{16{s & f[15]}}, f};
  endfunction

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = dataOut[0:7];
    case (offset)
      2'd0:    byteSel = dataOut[0:7];
      2'd1:    byteSel = dataOut[8:15];
      2'd2:    byteSel = dataOut[16:23];
      default: byteSel = dataOut[24:31];
    endcase
  end

  // The low offset bit is ignored for halfwords, so odd offsets fall back to the even one.
  assign halfSel = offset[0] ? dataOut[16:31] : dataOut[0:15];

  always_comb begin
    case (dSize)
      DSZ_BYTE: word = extendByte(byteSel, loadSign);
      DSZ_HALF: word = extendHalf(halfSel, loadSign);
      default:  word = dataOut;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register, integer result select and FP write port with two-beat double writes.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] nextPC_in,
  input  logic [0:4]  destReg_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] dataOut_in,
  input  logic        PCtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        loadSign_in,
  input  logic [0:1]  DSize_in,
  input  logic [0:4]  fDestReg_in,
  input  logic [0:63] fbusW_in,
  input  logic        FPRegWrite_in,
  input  logic        fpDouble_in,
  input  logic        mul_in,
  input  logic        valid_in,
  output logic        regWrite_out,
  output logic [0:4]  regDest_out,
  output logic [0:31] regData_out,
  output logic        fpWrite_out,
  output logic [0:4]  fpDest_out,
  output logic [0:31] fpData_out,
  output logic        stall_out,
  output logic        mul_retired
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [0:CNT_W-1] retired_count
`endif
);

  import writeback_stage_pkg::*;

  logic [0:31] nextPC_p0, aluResult_p0, dataOut_p0;
  logic [0:4]  destReg_p0, fDestReg_p0;
  logic [0:63] fbusW_p0;
  logic [0:1]  dSize_p0;
  logic        pcToReg_p0, regWrite_p0, memToReg_p0, loadSign_p0;
  logic        fpRegWrite_p0, fpDouble_p0, mul_p0, vld_p0;
  wbState_t    state_p0;
  logic [0:31] loadWord;
  logic        dblStart, inLo;

  // ---- MEM/WB boundary: capture unless the double-write sequence is holding the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nextPC_p0     <= RESET_PC;
      aluResult_p0  <= '0;
      dataOut_p0    <= '0;
      destReg_p0    <= '0;
      fDestReg_p0   <= '0;
      fbusW_p0      <= '0;
      dSize_p0      <= '0;
      pcToReg_p0    <= 1'b0;
      regWrite_p0   <= 1'b0;
      memToReg_p0   <= 1'b0;
      loadSign_p0   <= 1'b0;
      fpRegWrite_p0 <= 1'b0;
      fpDouble_p0   <= 1'b0;
      mul_p0        <= 1'b0;
      vld_p0        <= 1'b0;
    end else if (!stall_out) begin
      nextPC_p0     <= nextPC_in;
      aluResult_p0  <= aluResult_in;
      dataOut_p0    <= dataOut_in;
      destReg_p0    <= destReg_in;
      fDestReg_p0   <= fDestReg_in;
      fbusW_p0      <= fbusW_in;
      dSize_p0      <= DSize_in;
      pcToReg_p0    <= PCtoReg_in;
      regWrite_p0   <= RegWrite_in;
      memToReg_p0   <= MemToReg_in;
      loadSign_p0   <= loadSign_in;
      fpRegWrite_p0 <= FPRegWrite_in;
      fpDouble_p0   <= fpDouble_in;
      mul_p0        <= mul_in;
      vld_p0        <= valid_in;
    end
  end

  assign dblStart = (state_p0 == WB_IDLE) && vld_p0 && fpRegWrite_p0 && fpDouble_p0;
  assign inLo     = (state_p0 == WB_WR_LO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= WB_IDLE;
    end else begin
      case (state_p0)
        WB_IDLE:  if (dblStart) state_p0 <= WB_WR_LO;
        default:  state_p0 <= WB_IDLE;
      endcase
    end
  end

  load_extend uLoadExtend (
    .dataOut  (dataOut_p0),
    .offset   (aluResult_p0[30:31]),
    .dSize    (dSize_p0),
    .loadSign (loadSign_p0),
    .word     (loadWord)
  );

  // ---- Writeback: combinational from the registered slot
  always_comb begin
    regData_out = aluResult_p0;
    if (pcToReg_p0)       regData_out = nextPC_p0;
    else if (memToReg_p0) regData_out = loadWord;
  end

  // The integer write already happened on the high beat, so the low beat suppresses it.
  assign regWrite_out = vld_p0 && regWrite_p0 && !inLo;
  assign regDest_out  = destReg_p0;
  assign fpWrite_out  = inLo || (vld_p0 && fpRegWrite_p0);
  assign fpDest_out   = inLo ? fDestReg_p0 + 5'd1 : fDestReg_p0;
  assign fpData_out   = inLo ? fbusW_p0[32:63] : fbusW_p0[0:31];
  assign stall_out    = dblStart;
  assign mul_retired  = vld_p0 && mul_p0;

`ifdef WB_RETIRE_CNT_EN
  logic [0:CNT_W-1] retireCnt_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              retireCnt_p0 <= '0;
    else if (inLo || (vld_p0 && !dblStart)) retireCnt_p0 <= retireCnt_p0 + 1'b1;
  end

  assign retired_count = retireCnt_p0;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage. Contains the MEM/WB pipeline register, load extraction/extension, and integer result selection, and drives the integer register-file write port. Drives the single 32-bit FP register-file write port. Double-precision FP results are written as two sequential 32-bit writes under a small FSM that stalls the upstream pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, reset value of the registered nextPC.
- CNT_W, 32, width of the optional retire counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- nextPC_in  in  [0:31]  PC+8 link value.
- destReg_in  in  [0:4]  integer destination register.
- aluResult_in  in  [0:31]  ALU result; bits [30:31] are the load byte offset.
- dataOut_in  in  [0:31]  aligned big-endian word read from data memory.
- PCtoReg_in, RegWrite_in, MemToReg_in, loadSign_in  in  1 each  control bits.
- DSize_in  in  [0:1]  00 byte, 01 halfword, 1x word.
- fDestReg_in  in  [0:4]  FP destination register.
- fbusW_in  in  [0:63]  FP result; [0:31] high word, [32:63] low word.
- FPRegWrite_in  in  1  FP write enable.
- fpDouble_in  in  1  FP result is double-precision.
- mul_in  in  1  result came from the multiplier; sets the mul_retired flag.
- valid_in  in  1  upstream slot holds a real instruction.
- regWrite_out  out  1  integer register-file write enable.
- regDest_out  out  [0:4]  integer write address.
- regData_out  out  [0:31]  integer write data.
- fpWrite_out  out  1  FP register-file write enable.
- fpDest_out  out  [0:4]  FP write address.
- fpData_out  out  [0:31]  FP write data.
- stall_out  out  1  upstream must hold; do not advance.
- mul_retired  out  1  registered mul bit of the retiring slot.

Behaviour:
- The register captures all *_in at posedge clk when stall_out=0. It holds when stall_out=1.
- Writeback data is combinational from the register, so a result is written one cycle after capture (latency 1).
- Reset: register cleared, valid=0, nextPC=RESET_PC, FSM=IDLE. All outputs read 0 during and after reset.
- All write enables are gated with the registered valid bit.
- Load extraction uses the registered aluResult[30:31]:
  - byte k (k=0..3) = dataOut[8k:8k+7].
  - halfword: offset 0 selects [0:15], offset 2 selects [16:31].
  - odd halfword offsets: treat bit 31 as 0.
  - word: ignore the offset.
- Extension: loadSign=1 sign-extends from the MSB of the extracted field; 0 zero-extends.
- regData priority: PCtoReg selects nextPC; else MemToReg selects the extended load; else aluResult.
- regWrite_out = valid & RegWrite. regWrite_out is never asserted in the WR_LO state.
- FSM states:
  - IDLE: fpWrite_out = valid & FPRegWrite, fpDest = fDestReg, fpData = fbusW[0:31]. If valid & FPRegWrite & fpDouble, assert stall_out=1 combinationally and go to WR_LO. Otherwise stall_out=0.
  - WR_LO: fpWrite_out=1, fpDest = fDestReg+1 (mod 32; fDestReg 31 wraps to 0), fpData = fbusW[32:63], stall_out=0. Return to IDLE; the register captures the next instruction at the same edge.
- A double with FPRegWrite=0 writes nothing and does not stall.
- Reset asserted in WR_LO aborts the low write and returns to IDLE.
- Simultaneous integer and FP writes in the same cycle are permitted; the ports are independent.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retired_count [0:CNT_W-1].
  - Increments once per retiring valid instruction: in IDLE when not entering WR_LO, and on the WR_LO cycle.
  - Wraps at 2^CNT_W. Cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: DSize encodings (DSZ_BYTE, DSZ_HALF, DSZ_WORD), FSM state constants (WB_IDLE, WB_WR_LO), word/double width constants.
- Sub-module load_extend: combinational extract plus sign/zero extension (inputs dataOut, offset, DSize, loadSign; output 32-bit word). Instanced once.

Test Plan:
- lb, offset 1, loadSign=1, dataOut=32'h12F4_5678, MemToReg=1, RegWrite=1, destReg=5 -> next cycle regWrite=1, regDest=5, regData=32'hFFFF_FFF4.
- lhu, offset 2, loadSign=0, dataOut=32'h1234_8001 -> regData=32'h0000_8001. Same with loadSign=1 -> 32'hFFFF_8001.
- jal: PCtoReg=1, nextPC=32'h0000_0108, destReg=31 -> regData=32'h0000_0108.
- FP double: fDestReg=6, fbusW=64'h4009_21FB_5444_2D18 -> cycle 1: fpDest=6, data 32'h4009_21FB, stall_out=1 with upstream held; cycle 2: fpDest=7, data 32'h5444_2D18, stall_out=0.
- Double with fDestReg=31 -> second write to register 0. Reset asserted during WR_LO -> fpWrite_out=0 immediately, FSM in IDLE.
- valid_in=0 with RegWrite=1 and FPRegWrite=1 -> no writes. With WB_RETIRE_CNT_EN, three singles plus one double -> retired_count=4.
